// File: rtl/prm_edge_mask_engine.sv
// PRM edge-blocking engine: per-edge swept-volume masks checked against an obstacle vector, LANES edges per cycle.
// Optional blocked-edge counter output is enabled by defining PRM_BLOCKED_COUNT_EN.
module prm_edge_mask_engine #(
  parameter int OBS_W   = 15,
  parameter int N_EDGES = 64,
  parameter int LANES   = 8,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [OBS_W-1:0]   cfg_data,
  output logic               cfg_err,
  input  logic               obs_valid,
  output logic               obs_ready,
  input  logic [OBS_W-1:0]   obs_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_EDGES-1:0] edge_mask,
  output logic               busy
`ifdef PRM_BLOCKED_COUNT_EN
  ,
  output logic [$clog2(N_EDGES+1)-1:0] blk_count
`endif
);

  localparam int PASSES = N_EDGES / LANES;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int EIDX_W = (N_EDGES > 1) ? $clog2(N_EDGES) : 1;
  localparam int CNT_W  = $clog2(N_EDGES + 1);
  localparam logic [ADDR_W:0] EDGE_LIM = N_EDGES[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q;
  logic [PASS_W-1:0]  pass_q;
  logic [OBS_W-1:0]   obs_q;
  logic [N_EDGES-1:0] edge_mask_q;
  logic               res_valid_q;
  logic               cfg_err_q;
  logic [OBS_W-1:0]   mask_q [N_EDGES];

  logic [ADDR_W:0]    addr_ext;
  logic               cfg_ok;
  logic [EIDX_W-1:0]  pass_base;
  logic [LANES-1:0]   lane_blk;

  // Zero-extended so the range check stays meaningful when ADDR_W exactly covers N_EDGES.
  assign addr_ext  = {1'b0, cfg_addr};
  assign cfg_ok    = (state_q == IDLE) && (addr_ext < EDGE_LIM);
  assign pass_base = EIDX_W'(int'(pass_q) * LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [EIDX_W-1:0] idx;
    assign idx         = EIDX_W'(int'(pass_q) * LANES + l);
    assign lane_blk[l] = |(obs_q & mask_q[idx]);
  end

`ifdef PRM_BLOCKED_COUNT_EN
  logic [CNT_W-1:0] blk_count_q;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_count_q <= '0;
    end else if (state_q == IDLE && obs_valid) begin
      blk_count_q <= '0;
    end else if (state_q == SCAN) begin
      blk_count_q <= blk_count_q + popcount(lane_blk);
    end
  end

  assign blk_count = blk_count_q;
`endif

  // Mask table: writes only land while idle, so a scan always sees a frozen table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < N_EDGES; e++) mask_q[e] <= '0;
    end else if (cfg_we && cfg_ok) begin
      mask_q[cfg_addr[EIDX_W-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      obs_q       <= '0;
      edge_mask_q <= '0;
      res_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      case (state_q)
        IDLE: begin
          if (obs_valid) begin
            obs_q       <= obs_data;
            pass_q      <= '0;
            edge_mask_q <= '0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          edge_mask_q[pass_base +: LANES] <= lane_blk;
          pass_q <= pass_q + 1'b1;
          if (pass_q == PASS_W'(PASSES - 1)) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign obs_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign edge_mask = edge_mask_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Randomised self-checking bench for prm_edge_mask_engine against a per-edge AND/OR reference model.
// Checks blk_count as well when PRM_BLOCKED_COUNT_EN is defined.
module tb_prm_edge_mask_engine;

  localparam int OBS_W   = 15;
  localparam int N_EDGES = 64;
  localparam int LANES   = 8;
  localparam int ADDR_W  = 7;
  localparam int LAT     = N_EDGES / LANES;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [OBS_W-1:0]   cfg_data;
  logic               cfg_err;
  logic               obs_valid;
  logic               obs_ready;
  logic [OBS_W-1:0]   obs_data;
  logic               res_valid;
  logic               res_ready;
  logic [N_EDGES-1:0] edge_mask;
  logic               busy;
`ifdef PRM_BLOCKED_COUNT_EN
  logic [$clog2(N_EDGES+1)-1:0] blk_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [OBS_W-1:0] model_mask [N_EDGES];

  prm_edge_mask_engine #(
    .OBS_W(OBS_W), .N_EDGES(N_EDGES), .LANES(LANES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_data(obs_data),
    .res_valid(res_valid), .res_ready(res_ready), .edge_mask(edge_mask), .busy(busy)
`ifdef PRM_BLOCKED_COUNT_EN
    , .blk_count(blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_EDGES-1:0] ref_mask(input logic [OBS_W-1:0] obs);
    logic [N_EDGES-1:0] r;
    for (int e = 0; e < N_EDGES; e++) r[e] = (obs & model_mask[e]) != '0;
    return r;
  endfunction

  task automatic clear_model();
    for (int e = 0; e < N_EDGES; e++) model_mask[e] = '0;
  endtask

  // Single idle-state config write; out-of-range addresses must be rejected.
  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [OBS_W-1:0] d);
    logic ok;
    ok = (int'(a) < N_EDGES);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("cfg_err_idle", 64'(cfg_err), 64'(!ok));
    if (ok) model_mask[int'(a)] = d;
  endtask

  // One query: optional config write in the accept cycle, optional write during SCAN,
  // then `stall` cycles of res_ready low with pend_obs offered on obs_valid.
  task automatic query(input logic [OBS_W-1:0] obs, input bit cw_en, input logic [ADDR_W-1:0] cw_addr,
                       input logic [OBS_W-1:0] cw_data, input bit scan_wr, input int stall,
                       input logic [OBS_W-1:0] pend_obs);
    logic [N_EDGES-1:0] exp;
    int lat;
    chk("obs_ready_idle", 64'(obs_ready), 64'd1);
    obs_valid = 1'b1; obs_data = obs;
    if (cw_en) begin
      cfg_we = 1'b1; cfg_addr = cw_addr; cfg_data = cw_data;
      model_mask[int'(cw_addr)] = cw_data;
    end
    exp = ref_mask(obs);
    @(posedge clk); #1;
    obs_valid = 1'b0; cfg_we = 1'b0;
    chk("busy_scan", 64'(busy), 64'd1);
    lat = 0;
    while (!res_valid && lat < LAT + 4) begin
      if (scan_wr && lat == 2) begin
        cfg_we = 1'b1; cfg_addr = 7'd5; cfg_data = 15'h7FFF;
      end
      @(posedge clk); #1;
      lat++;
      if (scan_wr && lat == 3) begin
        cfg_we = 1'b0;
        chk("cfg_err_scan", 64'(cfg_err), 64'd1);
      end
      if (scan_wr && lat == 4) chk("cfg_err_one_cycle", 64'(cfg_err), 64'd0);
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("edge_mask", 64'(edge_mask), 64'(exp));
`ifdef PRM_BLOCKED_COUNT_EN
    chk("blk_count", 64'(blk_count), 64'($countones(exp)));
`endif
    if (stall > 0) begin
      obs_valid = 1'b1; obs_data = pend_obs; res_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("stall_mask_stable", 64'(edge_mask), 64'(exp));
        chk("stall_obs_ready", 64'(obs_ready), 64'd0);
        chk("stall_res_valid", 64'(res_valid), 64'd1);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_clear", 64'(res_valid), 64'd0);
    chk("idle_after_hs", 64'(obs_ready), 64'd1);
    chk("mask_held", 64'(edge_mask), 64'(exp));
  endtask

  initial begin
    logic [OBS_W-1:0] o, pend;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    obs_valid = 1'b0; obs_data = '0; res_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_obs_ready", 64'(obs_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_edge_mask", 64'(edge_mask), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    query(15'h7FFF, 0, '0, '0, 0, 0, '0);

    cfg_write(7'd0, 15'h0001);
    cfg_write(7'd63, 15'h4000);
    query(15'h4001, 0, '0, '0, 0, 0, '0);
    chk("two_edge_result", 64'(edge_mask), 64'h8000_0000_0000_0001);

    // Stall in DONE with a pending query; it must be taken right after the handshake.
    pend = 15'h0001;
    query(15'h4000, 0, '0, '0, 0, 5, pend);
    query(pend, 0, '0, '0, 0, 0, '0);

    // Writes during SCAN and to an out-of-range address are dropped.
    query(15'h0020, 0, '0, '0, 1, 0, '0);
    cfg_write(7'd64, 15'h7FFF);
    cfg_write(7'd127, 15'h7FFF);
    query(15'h7FFF, 0, '0, '0, 0, 0, '0);
    chk("dropped_writes", 64'(edge_mask), 64'h8000_0000_0000_0001);

    for (int e = 0; e < N_EDGES - 1; e++) cfg_write(ADDR_W'(e), 15'h0100);
    query(15'h0100, 1, 7'd63, 15'h0100, 0, 0, '0);
    chk("all_blocked", 64'(edge_mask), 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset in the middle of a scan.
    obs_valid = 1'b1; obs_data = 15'h0100;
    @(posedge clk); #1;
    obs_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_obs_ready", 64'(obs_ready), 64'd1);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_edge_mask", 64'(edge_mask), 64'd0);
    #2 rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    query(15'h7FFF, 0, '0, '0, 0, 0, '0);

    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 6; w++)
        cfg_write(ADDR_W'($urandom_range(0, N_EDGES - 1)),
                  OBS_W'($urandom) & OBS_W'($urandom) & OBS_W'($urandom));
      o = OBS_W'($urandom) & OBS_W'($urandom);
      query(o, 0, '0, '0, 0, $urandom_range(0, 2), o);
      obs_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
